uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter among NUM_REQ byte producers. Sits between the
//  requesters and the UART's enable/i_data/o_busy interface. Picks a requester
//  round-robin, latches its byte and pulses UART enable for one cycle.
//  Tracks the frame through o_busy and reports completion and timeouts.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  DATA_WIDTH    8    byte width, matches UART INPUT_DATA_WIDTH
//  BUSY_TIMEOUT  16   max cycles from enable pulse to uart_busy rising
// PORTS
//  clk            in   1                   system clock
//  reset          in   1                   asynchronous, active-low reset
//  req_valid      in   NUM_REQ             requester i has a byte pending
//  req_data       in   NUM_REQ*DATA_WIDTH  byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready      out  NUM_REQ             one-cycle accept pulse, one-hot
//  uart_enable    out  1                   to UART enable, one-cycle pulse
//  uart_data      out  DATA_WIDTH          to UART i_data, held for whole frame
//  uart_busy      in   1                   from UART o_busy
//  grant_id       out  clog2(NUM_REQ)      index of requester being served
//  tx_done        out  1                   one-cycle pulse when frame completes
//  timeout_err    out  1                   sticky: uart_busy never rose
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, req_ready=0, uart_enable=0,
//   uart_data=0, grant_id=0, tx_done=0, timeout_err=0, rr_ptr=0, tmo_cnt=0.
//  All outputs are registered. No combinational path from input to output.
//  Requester rule: hold req_valid and req_data stable until req_ready pulses.
//   Dropping valid before the grant is legal. The byte is then not sent.
//  FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
//  IDLE: at an edge with |req_valid && !uart_busy:
//   - g = first set bit of req_valid, searching from rr_ptr upward and wrapping.
//   - uart_data<=req_data[g]; grant_id<=g; req_ready[g]<=1; uart_enable<=1.
//   - Next state is LAUNCH.
//   If uart_busy=1 in IDLE, stay in IDLE and grant nothing.
//   This means enable is never asserted while the UART is busy.
//  LAUNCH (exactly 1 cycle): req_ready and uart_enable are high in this cycle.
//   Both are cleared at the next edge. tmo_cnt<=0. Next state is WAIT_BUSY.
//  WAIT_BUSY: if uart_busy=1, go to WAIT_DONE.
//   Otherwise tmo_cnt++. When tmo_cnt==BUSY_TIMEOUT-1:
//    timeout_err<=1, rr_ptr<=g+1 (mod NUM_REQ), go to IDLE.
//  WAIT_DONE: when uart_busy=0: tx_done<=1 for one cycle,
//   rr_ptr<=g+1 (mod NUM_REQ), go to IDLE.
//  Latency: req_valid sampled at edge k -> req_ready/uart_enable high in
//   cycle k..k+1. A new grant is possible at the edge right after tx_done.
//  rr_ptr wraps NUM_REQ-1 -> 0. A lone requester is granted back-to-back.
//  timeout_err is cleared only by reset.
//  uart_data and grant_id hold their values until the next grant.
//  Reset mid-frame: the FSM returns to IDLE and no tx_done is generated.
//   The UART is expected to be reset from the same source.
// STRUCTURE
//  uart_arb_defs.vh: FSM state localparams (2-bit).
//  Sub-module uart_rr_pick: combinational round-robin picker.
//   Inputs req_valid and rr_ptr. Outputs one-hot grant, index and any_valid.
//  Top level: FSM, data/grant registers and timeout counter.
// TESTING
//  1 Single: req_valid=4'b0100, data2=8'hA5 -> req_ready=4'b0100 and
//    uart_enable for 1 cycle, uart_data=A5, grant_id=2. tx_done follows the
//    UART frame. Loopback receiver yields A5.
//  2 Fairness: all 4 valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0.
//    Exactly one req_ready per frame.
//  3 Busy guard: force uart_busy=1 while req_valid=1 in IDLE -> no
//    uart_enable and no req_ready until busy drops.
//  4 Timeout: stub UART keeps busy=0 -> timeout_err=1 after 16 WAIT_BUSY
//    cycles, then the next requester is granted normally.
//  5 Reset mid-frame: assert reset during WAIT_DONE -> all outputs 0
//    immediately (async), no tx_done pulse, rr_ptr=0.
//  6 Wrap: only req 3 valid then only req 0 valid -> grants 3 then 0.
//    rr_ptr wraps to 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_pkg
//  Purpose  : Shared FSM state encoding for the UART transmit arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rr_pick
//  Purpose  : Combinational round-robin picker: first valid requester at or
//             above rr_ptr, wrapping past NUM_REQ-1 back to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] index_o,
    output logic                       any_valid_o
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_SUM_W = c_IDX_W + 1;

    logic [c_SUM_W-1:0] w_sum;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_found;

    // One extra bit holds rr_ptr+k before the modulo fold.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, rr_ptr_i} + c_SUM_W'(k);
            if (w_sum >= c_SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - c_SUM_W'(NUM_REQ);
            end
            w_idx = w_sum[c_IDX_W-1:0];
            if (!w_found && req_valid_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                index_o        = w_idx;
            end
        end
    end

    assign any_valid_o = |req_valid_i;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin sharing of one UART transmitter among NUM_REQ byte
//             producers, with frame tracking, completion and timeout report.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_enable,
    output logic [DATA_WIDTH-1:0]         uart_data,
    input  logic                          uart_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          tx_done,
    output logic                          timeout_err
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(BUSY_TIMEOUT - 1);

    arb_state_t                state_q, state_d;
    logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
    logic                      uart_enable_q, uart_enable_d;
    logic [DATA_WIDTH-1:0]     uart_data_q, uart_data_d;
    logic [c_IDX_W-1:0]        grant_id_q, grant_id_d;
    logic [c_IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                      tx_done_q, tx_done_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [c_TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0]        w_pick_grant;
    logic [c_IDX_W-1:0]        w_pick_idx;
    logic                      w_pick_any;
    logic [c_IDX_W-1:0]        w_next_ptr;
    logic [DATA_WIDTH-1:0]     w_req_byte [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_byte[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (w_pick_grant),
        .index_o     (w_pick_idx),
        .any_valid_o (w_pick_any)
    );

    // Priority moves just past whoever was served, whether it finished or timed out.
    assign w_next_ptr = (grant_id_q == c_LAST_IDX) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        req_ready_d   = '0;
        uart_enable_d = 1'b0;
        uart_data_d   = uart_data_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        tx_done_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any && !uart_busy) begin
                    uart_data_d   = w_req_byte[w_pick_idx];
                    grant_id_d    = w_pick_idx;
                    req_ready_d   = w_pick_grant;
                    uart_enable_d = 1'b1;
                    state_d       = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == c_TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = w_next_ptr;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    tx_done_d = 1'b1;
                    rr_ptr_d  = w_next_ptr;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= '0;
            uart_enable_q <= 1'b0;
            uart_data_q   <= '0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            tx_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            uart_enable_q <= uart_enable_d;
            uart_data_q   <= uart_data_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            tx_done_q     <= tx_done_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign uart_enable = uart_enable_q;
    assign uart_data   = uart_data_q;
    assign grant_id    = grant_id_q;
    assign tx_done     = tx_done_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench: frame-level reference model, UART stub and
//             directed plus randomized requester traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic            uart_busy;
    logic [N-1:0]    req_ready;
    logic            uart_enable;
    logic [DW-1:0]   uart_data;
    logic [1:0]      grant_id;
    logic            tx_done;
    logic            timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .uart_enable (uart_enable),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy),
        .grant_id    (grant_id),
        .tx_done     (tx_done),
        .timeout_err (timeout_err)
    );

    int total = 0;
    int bad   = 0;

    bit           rand_mode  = 1'b0;
    bit           force_busy = 1'b0;
    bit           stub_dead  = 1'b0;
    bit           stub_long  = 1'b0;
    logic [N-1:0] refill     = '0;
    int           n_done     = 0;

    // ---------------- UART stub: busy rises 1..4 cycles after enable ----------
    bit           s_busy    = 1'b0;
    int           sst       = 0;
    int           sdel      = 0;
    int           slen      = 0;
    logic [DW-1:0] cap      = '0;
    int           held_bad  = 0;

    assign uart_busy = s_busy | force_busy;

    always @(negedge clk) begin
        if (!reset) begin
            s_busy <= 1'b0;
            sst    <= 0;
        end else if (uart_enable && !stub_dead) begin
            cap    <= uart_data;
            sdel   <= $urandom_range(0, 3);
            slen   <= stub_long ? 30 : $urandom_range(1, 6);
            sst    <= 1;
            s_busy <= 1'b0;
        end else if (sst == 1) begin
            if (sdel == 0) begin
                s_busy <= 1'b1;
                sst    <= 2;
            end else begin
                sdel <= sdel - 1;
            end
        end else if (sst == 2) begin
            if (uart_data !== cap) held_bad <= held_bad + 1;
            if (slen == 0) begin
                s_busy <= 1'b0;
                sst    <= 0;
            end else begin
                slen <= slen - 1;
            end
        end
    end

    // ---------------- Frame-level reference model ----------------
    // A frame is timestamped at its grant edge; everything else is edge
    // arithmetic relative to that stamp.
    int            ecnt   = 0;
    bit            m_act  = 1'b0;
    bit            m_seen = 1'b0;
    int            m_tg   = 0;
    int            m_ptr  = 0;
    int            m_g    = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_err  = 1'b0;
    logic [N-1:0]  e_ready = '0;
    bit            e_en    = 1'b0;
    bit            e_done  = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int g;
        ecnt    <= ecnt + 1;
        e_ready <= '0;
        e_en    <= 1'b0;
        e_done  <= 1'b0;
        if (!reset) begin
            m_act  <= 1'b0;
            m_ptr  <= 0;
            m_err  <= 1'b0;
            m_g    <= 0;
            m_data <= '0;
        end else if (!m_act) begin
            if (req_valid != '0 && !uart_busy) begin
                g = pick(req_valid, m_ptr);
                m_g        <= g;
                m_data     <= req_data[g*DW +: DW];
                e_ready    <= N'(1) << g;
                e_en       <= 1'b1;
                m_act      <= 1'b1;
                m_seen     <= 1'b0;
                m_tg       <= ecnt;
            end
        end else if (ecnt > m_tg + 1) begin
            if (!m_seen) begin
                if (uart_busy) begin
                    m_seen <= 1'b1;
                end else if (ecnt - m_tg - 1 == TMO) begin
                    m_err <= 1'b1;
                    m_ptr <= (m_g + 1) % N;
                    m_act <= 1'b0;
                end
            end else if (!uart_busy) begin
                e_done <= 1'b1;
                m_ptr  <= (m_g + 1) % N;
                m_act  <= 1'b0;
            end
        end
    end

    // ---------------- Checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare DUT against model, then act as the requesters.
    task automatic step();
        @(negedge clk);
        chk("cyc_ready", 32'(req_ready),   32'(e_ready));
        chk("cyc_en",    32'(uart_enable), 32'(e_en));
        chk("cyc_data",  32'(uart_data),   32'(m_data));
        chk("cyc_gid",   32'(grant_id),    32'(m_g));
        chk("cyc_done",  32'(tx_done),     32'(e_done));
        chk("cyc_err",   32'(timeout_err), 32'(m_err));
        if (tx_done) n_done++;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                if (refill[i]) req_data[i*DW +: DW] = DW'($urandom);
                else           req_valid[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i]          = 1'b1;
                        req_data[i*DW +: DW]  = DW'($urandom);
                    end
                end else if (!req_ready[i] && $urandom_range(0, 63) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 40) == 0) force_busy = !force_busy;
        end
    endtask

    task automatic wait_en(input string nm, output int gid);
        for (int n = 0; n < 300; n++) begin
            step();
            if (uart_enable) break;
        end
        chk({nm, "_enable_seen"}, 32'(uart_enable), 32'd1);
        gid = int'(grant_id);
    endtask

    task automatic wait_done(input string nm);
        for (int n = 0; n < 300; n++) begin
            step();
            if (tx_done) break;
        end
        chk({nm, "_done_seen"}, 32'(tx_done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    // ---------------- Test sequence ----------------
    initial begin : main
        int gid;
        int cnt;
        int nd;
        int fair_exp [5] = '{0, 1, 2, 3, 0};

        repeat (3) step();
        chk("rst_ready", 32'(req_ready),   32'd0);
        chk("rst_en",    32'(uart_enable), 32'd0);
        chk("rst_data",  32'(uart_data),   32'd0);
        chk("rst_gid",   32'(grant_id),    32'd0);
        chk("rst_done",  32'(tx_done),     32'd0);
        chk("rst_err",   32'(timeout_err), 32'd0);
        reset = 1'b1;
        step();

        // Single requester, loopback byte
        req_data[2*DW +: DW] = 8'hA5;
        req_valid = 4'b0100;
        wait_en("single", gid);
        chk("single_gid",   32'(gid),       32'd2);
        chk("single_ready", 32'(req_ready), 32'b0100);
        chk("single_data",  32'(uart_data), 32'hA5);
        step();
        chk("single_en_pulse",    32'(uart_enable), 32'd0);
        chk("single_ready_pulse", 32'(req_ready),   32'd0);
        wait_done("single");
        chk("single_loopback", 32'(cap), 32'hA5);

        // Fairness from rr_ptr=0 with everybody pending
        do_reset();
        refill    = 4'hF;
        req_data  = 32'h44332211;
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_en("fair", gid);
            chk("fair_gid",   32'(gid),       32'(fair_exp[j]));
            chk("fair_ready", 32'(req_ready), 32'(4'b0001 << fair_exp[j]));
        end
        refill    = '0;
        req_valid = '0;
        wait_done("fair");

        // Wrap: 3 then 0
        req_data[3*DW +: DW] = 8'h5A;
        req_valid = 4'b1000;
        wait_en("wrap3", gid);
        chk("wrap_gid3", 32'(gid), 32'd3);
        wait_done("wrap3");
        req_valid = 4'b0011;
        wait_en("wrap0", gid);
        chk("wrap_gid0", 32'(gid), 32'd0);
        req_valid = '0;
        wait_done("wrap0");

        // Busy guard
        force_busy = 1'b1;
        repeat (2) step();
        req_data[2*DW +: DW] = 8'hC3;
        req_valid = 4'b0100;
        cnt = 0;
        repeat (12) begin
            step();
            if (uart_enable || req_ready != '0) cnt++;
        end
        chk("guard_no_grant", 32'(cnt), 32'd0);
        force_busy = 1'b0;
        wait_en("guard", gid);
        chk("guard_gid", 32'(gid), 32'd2);
        wait_done("guard");

        // Timeout: stub never raises busy
        stub_dead = 1'b1;
        refill    = 4'b0011;
        req_valid = 4'b0011;
        wait_en("tmo", gid);
        chk("tmo_gid", 32'(gid), 32'd0);
        cnt = 0;
        while (!timeout_err && cnt < 40) begin
            step();
            cnt++;
        end
        chk("tmo_cycles", 32'(cnt), 32'd17);
        stub_dead = 1'b0;
        wait_en("tmo_next", gid);
        chk("tmo_next_gid", 32'(gid), 32'd1);
        refill    = '0;
        req_valid = '0;
        wait_done("tmo_next");
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a long frame
        stub_long = 1'b1;
        req_data[2*DW +: DW] = 8'h3C;
        req_valid = 4'b0100;
        wait_en("mid", gid);
        chk("mid_gid", 32'(gid), 32'd2);
        cnt = 0;
        while (!uart_busy && cnt < 20) begin
            step();
            cnt++;
        end
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("mid_ready", 32'(req_ready),   32'd0);
        chk("mid_en",    32'(uart_enable), 32'd0);
        chk("mid_data",  32'(uart_data),   32'd0);
        chk("mid_gid0",  32'(grant_id),    32'd0);
        chk("mid_done",  32'(tx_done),     32'd0);
        chk("mid_err",   32'(timeout_err), 32'd0);
        nd = n_done;
        repeat (3) step();
        reset     = 1'b1;
        stub_long = 1'b0;
        repeat (40) step();
        chk("mid_no_done", 32'(n_done), 32'(nd));
        req_valid = 4'hF;
        wait_en("mid_after", gid);
        chk("mid_ptr0", 32'(gid), 32'd0);
        req_valid = '0;
        wait_done("mid_after");

        // Random traffic against the model
        refill    = N'($urandom);
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode  = 1'b0;
        force_busy = 1'b0;
        refill     = '0;
        req_valid  = '0;
        repeat (60) step();
        chk("data_held_in_frame", 32'(held_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
